// File: rtl/exe_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : exe_trace_buffer
//  Purpose  : Circular execution-trace FIFO fed by the execute-stage retire
//             stream (pc/instr). Capture can wait for a trigger PC, and on
//             full either freezes or overwrites the oldest entry (sticky
//             overflow). A debug reader drains entries over a show-ahead
//             valid/ready port.
//  Ports    : clk, reset (async, active-high)
//             i_system_ena, i_pause, i_exe_valid, i_exe_pc, i_exe_instr
//             i_trig_en, i_trig_pc, i_clear, i_rd_ready
//             o_rd_valid, o_rd_pc, o_rd_instr, o_rd_seq   head entry (0 if empty)
//             o_count, o_overflow, o_state (0 ARMED, 1 CAPTURE, 2 FROZEN)
//  Revision : 1.0  initial release
// ============================================================================
module exe_trace_buffer #(
    parameter int DEPTH        = 16,
    parameter int ADDR_W       = 4,
    parameter int STOP_ON_FULL = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_system_ena,
    input  logic              i_pause,
    input  logic              i_exe_valid,
    input  logic [31:0]       i_exe_pc,
    input  logic [31:0]       i_exe_instr,
    input  logic              i_trig_en,
    input  logic [31:0]       i_trig_pc,
    input  logic              i_clear,
    input  logic              i_rd_ready,
    output logic              o_rd_valid,
    output logic [31:0]       o_rd_pc,
    output logic [31:0]       o_rd_instr,
    output logic [15:0]       o_rd_seq,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic [1:0]        o_state
);

    typedef enum logic [1:0] {
        ST_ARMED   = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_FROZEN  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] c_full_count   = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W:0] c_almost_full  = (ADDR_W+1)'(DEPTH - 1);
    localparam logic [ADDR_W:0] c_count_one    = (ADDR_W+1)'(1);
    localparam logic [ADDR_W-1:0] c_ptr_one    = ADDR_W'(1);

    state_t              r_state;
    state_t              w_state_nxt;
    logic [ADDR_W-1:0]   r_wr_ptr;
    logic [ADDR_W-1:0]   r_rd_ptr;
    logic [ADDR_W:0]     r_count;
    logic                r_overflow;
    logic [15:0]         r_seq;

    // Trace storage is intentionally not reset; outputs are gated by rd_valid.
    logic [31:0]         r_mem_pc    [DEPTH];
    logic [31:0]         r_mem_instr [DEPTH];
    logic [15:0]         r_mem_seq   [DEPTH];

    logic w_cap_ok;
    logic w_push_req;
    logic w_pop;
    logic w_full;
    logic w_rd_valid;
    logic w_block;
    logic w_write;
    logic w_overwrite;

    assign w_cap_ok   = i_system_ena & ~i_pause & i_exe_valid;
    assign w_full     = (r_count == c_full_count);
    assign w_rd_valid = (r_count != '0);
    assign w_pop      = w_rd_valid & i_rd_ready;

    always_comb begin
        w_push_req = 1'b0;
        case (r_state)
            ST_ARMED:   w_push_req = w_cap_ok & (~i_trig_en | (i_exe_pc == i_trig_pc));
            ST_CAPTURE: w_push_req = w_cap_ok;
            default:    w_push_req = 1'b0;
        endcase
    end

    // In freeze mode a full FIFO only accepts a push that is paired with a pop;
    // in practice the FSM is already FROZEN by then, this is belt and braces.
    assign w_block     = (STOP_ON_FULL != 0) & w_full & ~w_pop;
    assign w_write     = w_push_req & ~w_block;
    // Full, pushing, not popping: the write slot is the oldest entry.
    assign w_overwrite = w_write & w_full & ~w_pop;

    always_comb begin
        w_state_nxt = r_state;
        if (i_clear) begin
            w_state_nxt = ST_ARMED;
        end else if ((STOP_ON_FULL != 0) && w_write && !w_pop && (r_count == c_almost_full)) begin
            w_state_nxt = ST_FROZEN;
        end else if ((r_state == ST_ARMED) && w_write) begin
            w_state_nxt = ST_CAPTURE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_ARMED;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_seq      <= '0;
        end else if (i_clear) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_seq      <= '0;
        end else begin
            if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
                r_seq    <= r_seq + 16'd1;
            end
            if (w_pop || w_overwrite) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            if (w_write && !w_pop && !w_full) begin
                r_count <= r_count + c_count_one;
            end else if (!w_write && w_pop) begin
                r_count <= r_count - c_count_one;
            end
            if (w_overwrite) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_write && !i_clear) begin
            r_mem_pc[r_wr_ptr]    <= i_exe_pc;
            r_mem_instr[r_wr_ptr] <= i_exe_instr;
            r_mem_seq[r_wr_ptr]   <= r_seq;
        end
    end

    assign o_rd_valid = w_rd_valid;
    assign o_rd_pc    = w_rd_valid ? r_mem_pc[r_rd_ptr]    : 32'd0;
    assign o_rd_instr = w_rd_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign o_rd_seq   = w_rd_valid ? r_mem_seq[r_rd_ptr]   : 16'd0;
    assign o_count    = r_count;
    assign o_overflow = r_overflow;
    assign o_state    = r_state;

endmodule
`default_nettype wire

// File: tb/tb_exe_trace_buffer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_exe_trace_buffer
//  Purpose  : Scoreboard bench for exe_trace_buffer. Two instances share the
//             stimulus: u_dut0 overwrites when full, u_dut1 freezes. A queue
//             model per instance holds the expected trace contents.
//  Revision : 1.0  initial release
// ============================================================================
module tb_exe_trace_buffer;

    logic        clk = 1'b0;
    logic        reset;
    logic        ena, pause, valid, trig_en, clr, ready;
    logic [31:0] pc, instr, trig_pc;

    logic        rd_valid [2];
    logic [31:0] rd_pc    [2];
    logic [31:0] rd_instr [2];
    logic [15:0] rd_seq   [2];
    logic [4:0]  count    [2];
    logic        overflow [2];
    logic [1:0]  state    [2];

    int n_vec = 0;
    int n_err = 0;

    // Reference model: expected FIFO contents {pc, instr, seq}, plus status.
    logic [79:0] q [2][$];
    int          m_state [2];   // 0 ARMED, 1 CAPTURE, 2 FROZEN
    bit          m_ovf   [2];
    logic [15:0] m_seq   [2];

    always #5 clk = ~clk;

    exe_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(0)) u_dut0 (
        .clk(clk), .reset(reset), .i_system_ena(ena), .i_pause(pause),
        .i_exe_valid(valid), .i_exe_pc(pc), .i_exe_instr(instr),
        .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_clear(clr), .i_rd_ready(ready),
        .o_rd_valid(rd_valid[0]), .o_rd_pc(rd_pc[0]), .o_rd_instr(rd_instr[0]),
        .o_rd_seq(rd_seq[0]), .o_count(count[0]), .o_overflow(overflow[0]),
        .o_state(state[0])
    );

    exe_trace_buffer #(.DEPTH(16), .ADDR_W(4), .STOP_ON_FULL(1)) u_dut1 (
        .clk(clk), .reset(reset), .i_system_ena(ena), .i_pause(pause),
        .i_exe_valid(valid), .i_exe_pc(pc), .i_exe_instr(instr),
        .i_trig_en(trig_en), .i_trig_pc(trig_pc), .i_clear(clr), .i_rd_ready(ready),
        .o_rd_valid(rd_valid[1]), .o_rd_pc(rd_pc[1]), .o_rd_instr(rd_instr[1]),
        .o_rd_seq(rd_seq[1]), .o_count(count[1]), .o_overflow(overflow[1]),
        .o_state(state[1])
    );

    task automatic chk(input string nm, input int k, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s[dut%0d] @%0t: got %h expected %h", nm, k, $time, act, exp);
        end
    endtask

    task automatic model_reset(input int k);
        q[k].delete();
        m_state[k] = 0;
        m_ovf[k]   = 1'b0;
        m_seq[k]   = 16'd0;
    endtask

    // Advance one model by the clock edge that will consume the current inputs.
    task automatic model_step(input int k, input bit sof);
        bit cap, push, pop;
        if (clr) begin
            model_reset(k);
            return;
        end
        cap = ena && !pause && valid;
        if (m_state[k] == 0)      push = cap && (!trig_en || pc == trig_pc);
        else if (m_state[k] == 1) push = cap;
        else                      push = 1'b0;
        pop = (q[k].size() != 0) && ready;
        if (pop) void'(q[k].pop_front());
        if (push && q[k].size() == 16) begin
            if (sof) push = 1'b0;
            else begin
                void'(q[k].pop_front());
                m_ovf[k] = 1'b1;
            end
        end
        if (push) begin
            q[k].push_back({pc, instr, m_seq[k]});
            m_seq[k] = m_seq[k] + 16'd1;
            if (m_state[k] == 0) m_state[k] = 1;
            if (sof && !pop && q[k].size() == 16) m_state[k] = 2;
        end
    endtask

    // Called at a falling edge with inputs already set; returns at the next one.
    task automatic tick();
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        @(negedge clk);
    endtask

    task automatic set_idle();
        ena = 1'b1; pause = 1'b0; valid = 1'b0; clr = 1'b0; ready = 1'b0;
        pc = 32'd0; instr = 32'd0;
    endtask

    task automatic push_pc(input logic [31:0] p);
        valid = 1'b1; pc = p; instr = $urandom;
        tick();
        valid = 1'b0;
    endtask

    task automatic do_clear();
        clr = 1'b1;
        tick();
        clr = 1'b0;
    endtask

    // Monitor: every cycle, shortly after the rising edge, compare each DUT
    // against its model; the head entry is compared whenever rd_valid is shown.
    always begin
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            logic [79:0] exp_head;
            exp_head = (q[k].size() != 0) ? q[k][0] : 80'd0;
            chk("rd_valid", k, 80'(rd_valid[k]), 80'(q[k].size() != 0));
            chk("head",     k, {rd_pc[k], rd_instr[k], rd_seq[k]}, exp_head);
            chk("count",    k, 80'(count[k]), 80'(q[k].size()));
            chk("overflow", k, 80'(overflow[k]), 80'(m_ovf[k]));
            chk("state",    k, 80'(state[k]), 80'(m_state[k]));
        end
    end

    initial begin
        reset = 1'b1;
        trig_en = 1'b0; trig_pc = 32'd0;
        set_idle();
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Free-running capture, three instructions then drain in order.
        push_pc(32'h0040_0000);
        push_pc(32'h0040_0004);
        push_pc(32'h0040_0008);
        chk("t1_count", 0, 80'(count[0]), 80'd3);
        chk("t1_ovf",   0, 80'(overflow[0]), 80'd0);
        ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk("t1_seq", 0, 80'(rd_seq[0]), 80'(i));
            chk("t1_pc",  0, 80'(rd_pc[0]), 80'(32'h0040_0000 + 4 * i));
            tick();
        end
        ready = 1'b0;

        // Trigger on PC 0x00400010.
        do_clear();
        trig_en = 1'b1; trig_pc = 32'h0040_0010;
        for (int i = 0; i < 9; i++) begin
            push_pc(32'h0040_0000 + 4 * i);
            chk("t2_state", 0, 80'(state[0]), (i >= 4) ? 80'd1 : 80'd0);
        end
        chk("t2_head_pc", 0, 80'(rd_pc[0]), 80'h0040_0010);
        chk("t2_count",   0, 80'(count[0]), 80'd5);
        trig_en = 1'b0;

        // Overwrite vs freeze: 20 pushes without pops.
        do_clear();
        for (int i = 0; i < 20; i++) push_pc(32'h0050_0000 + 4 * i);
        chk("t4_count", 0, 80'(count[0]), 80'd16);
        chk("t4_ovf",   0, 80'(overflow[0]), 80'd1);
        chk("t4_seq",   0, 80'(rd_seq[0]), 80'd4);
        chk("t4_state", 0, 80'(state[0]), 80'd1);
        chk("t5_state", 1, 80'(state[1]), 80'd2);
        chk("t5_count", 1, 80'(count[1]), 80'd16);
        ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t5_seq", 1, 80'(rd_seq[1]), 80'(i));
            tick();
        end
        ready = 1'b0;
        chk("t5_frozen", 1, 80'(state[1]), 80'd2);
        chk("t5_empty",  1, 80'(count[1]), 80'd0);

        // Full FIFO: simultaneous push+pop, then clear racing a push.
        do_clear();
        chk("t6_armed", 1, 80'(state[1]), 80'd0);
        for (int i = 0; i < 16; i++) push_pc(32'h0060_0000 + 4 * i);
        ready = 1'b1;
        push_pc(32'h0060_0100);
        ready = 1'b0;
        chk("t6_count", 0, 80'(count[0]), 80'd16);
        chk("t6_ovf",   0, 80'(overflow[0]), 80'd0);
        chk("t6_frz_pop", 1, 80'(count[1]), 80'd15);
        clr = 1'b1;
        push_pc(32'h0060_0200);
        clr = 1'b0;
        for (int k = 0; k < 2; k++) begin
            chk("t6_clr_count", k, 80'(count[k]), 80'd0);
            chk("t6_clr_state", k, 80'(state[k]), 80'd0);
        end

        // Pause and system_ena gate capture; pops still drain.
        for (int i = 0; i < 3; i++) push_pc(32'h0070_0000 + 4 * i);
        pause = 1'b1;
        for (int i = 0; i < 5; i++) push_pc(32'h0070_0100 + 4 * i);
        chk("t3_pause", 0, 80'(count[0]), 80'd3);
        pause = 1'b0; ena = 1'b0;
        for (int i = 0; i < 5; i++) push_pc(32'h0070_0200 + 4 * i);
        chk("t3_ena", 0, 80'(count[0]), 80'd3);
        ena = 1'b1; pause = 1'b1; ready = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("t3_drain", 0, 80'(count[0]), 80'd0);
        set_idle();

        // Randomized traffic with occasional clears and trigger hits.
        trig_pc = 32'h0040_001C;
        for (int i = 0; i < 400; i++) begin
            ena     = ($urandom_range(0, 9) != 0);
            pause   = ($urandom_range(0, 7) == 0);
            valid   = ($urandom_range(0, 3) != 0);
            pc      = 32'h0040_0000 + 4 * $urandom_range(0, 15);
            instr   = $urandom;
            trig_en = 1'($urandom_range(0, 1));
            clr     = ($urandom_range(0, 49) == 0);
            ready   = ($urandom_range(0, 2) == 0);
            tick();
        end
        set_idle();
        trig_en = 1'b0;

        // Asynchronous reset in the middle of a non-empty capture.
        do_clear();
        push_pc(32'h0080_0000);
        push_pc(32'h0080_0004);
        chk("pre_rst_valid", 0, 80'(rd_valid[0]), 80'd1);
        model_step(0, 1'b0);
        model_step(1, 1'b1);
        #2 reset = 1'b1;
        #1;
        for (int k = 0; k < 2; k++) begin
            chk("arst_valid", k, 80'(rd_valid[k]), 80'd0);
            chk("arst_count", k, 80'(count[k]), 80'd0);
        end
        #1 reset = 1'b0;
        model_reset(0);
        model_reset(1);
        @(negedge clk);
        push_pc(32'h0090_0000);
        chk("post_rst_seq", 0, 80'(rd_seq[0]), 80'd0);
        tick();

        @(posedge clk);
        #2;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
